// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin register arbiter.
// Imported by the arbiter top and its priority-search sub-module.
package rr_arb_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  localparam int MAX_N = 8;

  localparam logic [7:0] BUSY_MAX = 8'd255;

  // Callers slice the low N bits; N never exceeds MAX_N.
  function automatic logic [MAX_N-1:0] onehot(input int idx);
    logic [MAX_N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Rotating-priority search: first set bit of eff starting at ptr.
// Purely combinational, one instance per arbiter.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eff,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] win
);

  int j;

  always_comb begin
    hit = 1'b0;
    win = '0;
    j   = 0;
    for (int o = 0; o < N; o++) begin
      j = int'(ptr) + o;
      if (j >= N) j = j - N;
      if (!hit && eff[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter sharing one W-bit holding register
// between N requesters; all outputs registered.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   q,
  output logic           valid,
  output logic [IW-1:0]  owner,
  output logic [7:0]     busy_cnt
);

  logic [IW-1:0]    ptr;
  logic [N-1:0]     eff;
  logic             hit;
  logic [IW-1:0]    win;
  logic [W-1:0]     win_data;
  logic [MAX_N-1:0] oh_full;
  logic [N-1:0]     win_oh;
  logic             contended;
  logic [IW-1:0]    ptr_next;

  // The requester granted last edge sits out this one.
  assign eff = req & ~grant;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .eff (eff),
    .ptr (ptr),
    .hit (hit),
    .win (win)
  );

  always_comb begin
    win_data = data_in[int'(win)*W +: W];
    oh_full  = onehot(int'(win));
    win_oh   = oh_full[N-1:0];
  end

  assign contended = (eff & (eff - 1'b1)) != '0;

  assign ptr_next = (win == IW'(N-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clock) begin
    if (clear) begin
      q        <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      owner    <= '0;
      busy_cnt <= '0;
      ptr      <= '0;
    end else begin
      if (contended && busy_cnt != BUSY_MAX)
        busy_cnt <= busy_cnt + 8'd1;
      if (hit) begin
        q     <= win_data;
        grant <= win_oh;
        owner <= win;
        valid <= 1'b1;
        ptr   <= ptr_next;
      end else begin
        grant <= '0;
      end
    end
  end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin write arbiter that shares one W-bit holding register (a bank of D flip-flops with clear) between N requesters.
- Each cycle it picks at most one requester and latches that requester's data into the shared register.
- It returns a one-cycle grant pulse to the winner and reports which requester currently owns the stored value.
- It sits between independent producer blocks and any consumer of the shared register output.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width of the shared register
- IW, $clog2(N), width of owner index (derived, not overridden)

Ports:
- clock, input, 1, single system clock; all state updates on the rising edge
- clear, input, 1, synchronous active-high reset
- req, input, N, per-requester write request; bit i is held high until grant[i] is seen
- data_in, input, N*W, packed request data; slice i is data_in[i*W +: W], and must be valid while req[i] is high
- grant, output, N, one-hot, one-cycle grant pulse to the requester whose data was latched
- q, output, W, shared register contents
- valid, output, 1, high once any write has occurred since clear
- owner, output, IW, index of the requester that last wrote q
- busy_cnt, output, 8, saturating count of cycles where a request lost arbitration

Behaviour:
- Clear has priority over all other inputs. At a rising edge with clear=1:
  - q=0, grant=0, valid=0, owner=0, busy_cnt=0
  - internal priority pointer ptr=0
  - req is ignored that cycle.
- Effective request: eff = req & ~grant. A requester cannot win in the cycle its grant is visible, so a late req drop never causes a double write.
- Selection (combinational):
  - Winner = first set bit of eff, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - With eff=0 there is no winner.
- Edge with clear=0 and a winner k:
  - q <= data_in slice k
  - grant <= one-hot(k); owner <= k; valid <= 1
  - ptr <= (k+1) mod N, wrapping from N-1 to 0
- Edge with clear=0 and no winner:
  - grant <= 0
  - q, owner, valid, ptr hold.
- Latency: req rising before edge E produces q updated and grant high after E, if that requester wins. This is one-cycle latency.
- Worst-case wait is N-1 grants. A continuously requesting client is served at least once every N winning cycles.
- busy_cnt: at each edge with clear=0, if popcount(eff) > 1, busy_cnt <= busy_cnt+1, saturating at 255 with no wrap.
- grant is never more than one-hot. grant is 0 in any cycle following an edge with no winner.
- Clear mid-stream: an in-flight grant is dropped (grant=0 after the clear edge). ptr restarts at 0, so requester 0 has first priority after clear.
- All outputs are registered. There are no combinational paths from req or data_in to any output.

Decomposition:
- Shared package rr_arb_pkg:
  - default N and W constants
  - function onehot(idx) returning an N-bit vector
  - constant BUSY_MAX=255
- Sub-module rr_pick: purely combinational rotate-priority search.
  - Inputs: eff[N], ptr[IW]
  - Outputs: hit, win[IW]
  - Instantiated once.
- rr_reg_arbiter holds all flops: q, grant, owner, valid, ptr, busy_cnt.

Test Plan:
- Clear held 2 cycles, req=4'b1111 → q=0, grant=0, valid=0, owner=0, busy_cnt=0 throughout. First edge after clear drops gives grant=4'b0001, q=data0.
- req=4'b1111 held constant, data_i = 8'hA0+i → grants cycle 0001, 0010, 0100, 1000, 0001. q follows A0, A1, A2, A3, A0. busy_cnt increments every cycle.
- Only req[2]=1, held 3 cycles → grant pattern 0100, 0000, 0100 (masking rule). q=data2. owner=2.
- ptr=3 (after a grant to 2), req=4'b1001 → grant 1000, then 0001 (wrap-around).
- req=0 for 5 cycles after writes → q, owner, valid stable; grant=0; busy_cnt unchanged.
- Force busy_cnt past 255 with 300 contended cycles → busy_cnt stays 255. Clear mid-sequence → all outputs 0 next edge, and the next grant goes to requester 0.
